// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, parity encodings and baud-divider helper for
//                the UART receive/transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Parity selection encodings
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per oversample tick, truncated
    function automatic int baud_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running divider producing a one-cycle strobe every DIV
//                clocks (oversample tick for the UART receiver/transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampler
//  Description : UART receive front-end. Synchronises the serial line,
//                oversamples each bit, majority-votes three mid-bit samples,
//                checks optional parity and the stop bit, and presents words
//                on a valid/ready interface with framing/parity/overrun status.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 7,
    parameter int OVERSAMPLE    = 16,
    parameter int PARITY        = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 rx_busy
);

    localparam int c_div   = baud_div(CLK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int c_mid   = OVERSAMPLE / 2;
    localparam int c_s_w   = $clog2(OVERSAMPLE);
    localparam int c_idx_w = $clog2(DATA_BITS);

    localparam logic [c_s_w-1:0]   c_s_early  = c_s_w'(c_mid - 1);
    localparam logic [c_s_w-1:0]   c_s_mid    = c_s_w'(c_mid);
    localparam logic [c_s_w-1:0]   c_s_vote   = c_s_w'(c_mid + 1);
    localparam logic [c_s_w-1:0]   c_s_last   = c_s_w'(OVERSAMPLE - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);
    localparam bit                 c_has_par  = (PARITY != PAR_NONE);
    localparam bit                 c_odd_par  = (PARITY == PAR_ODD);

    logic                 r_sync1, r_sync2;
    logic                 w_line, w_tick;
    rx_state_t            r_state, w_state_next;
    logic [c_s_w-1:0]     r_s, w_s_idx;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_samp_early, r_samp_mid;
    logic                 w_vote, w_vote_tick, w_bit_end;
    logic                 r_armed, w_start_det, w_done;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err, w_par_exp;
    logic                 r_done, r_done_ferr, r_done_perr;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Two-flop synchroniser; line idles high so flops reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;

    // Index of the current tick within the bit (r_s holds the previous one)
    assign w_s_idx     = (r_s == c_s_last) ? '0 : r_s + c_s_w'(1);
    assign w_vote_tick = w_tick && (w_s_idx == c_s_vote);
    assign w_bit_end   = w_tick && (w_s_idx == c_s_last);
    assign w_vote      = (r_samp_early & r_samp_mid) | (r_samp_early & w_line) |
                         (r_samp_mid & w_line);
    assign w_par_exp   = c_odd_par ? ~(^r_shift) : ^r_shift;

    // Frame state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; STOP leaves at the vote so a back-to-back start is seen
    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_tick && !w_line && r_armed) begin
                    w_start_det  = 1'b1;
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (w_vote_tick && w_vote) begin
                    w_state_next = RX_IDLE;
                end else if (w_bit_end) begin
                    w_state_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_end && (r_idx == c_idx_last)) begin
                    w_state_next = c_has_par ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_vote_tick) begin
                    w_done       = 1'b1;
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // Sample counter, bit index, vote samples, data/parity capture and the
    // idle arming flag that blocks re-triggering on a held-low (break) line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s          <= '0;
            r_idx        <= '0;
            r_samp_early <= 1'b0;
            r_samp_mid   <= 1'b0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_armed      <= 1'b0;
        end else if (r_state == RX_IDLE) begin
            r_s       <= '0;
            r_idx     <= '0;
            r_par_err <= 1'b0;
            if (w_tick && w_line) begin
                r_armed <= 1'b1;
            end else if (w_start_det) begin
                r_armed <= 1'b0;
            end
        end else if (w_tick) begin
            r_s <= w_s_idx;
            if (w_s_idx == c_s_early) begin
                r_samp_early <= w_line;
            end
            if (w_s_idx == c_s_mid) begin
                r_samp_mid <= w_line;
            end
            if (w_vote_tick && (r_state == RX_DATA)) begin
                r_shift[r_idx] <= w_vote;
            end
            if (w_vote_tick && (r_state == RX_PARITY)) begin
                r_par_err <= (w_vote != w_par_exp);
            end
            if (w_bit_end && (r_state == RX_DATA)) begin
                r_idx <= r_idx + c_idx_w'(1);
            end
        end
    end

    // Register the stop vote so delivery happens in the following cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done      <= 1'b0;
            r_done_ferr <= 1'b0;
            r_done_perr <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_done) begin
                r_done_ferr <= ~w_vote;
                r_done_perr <= r_par_err;
            end
        end
    end

    // Output word holding register with consume/reload and overrun pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            if (r_done && (!rx_valid || rx_ready)) begin
                rx_data       <= r_shift;
                framing_error <= r_done_ferr;
                parity_error  <= r_done_perr;
                rx_valid      <= 1'b1;
            end else begin
                if (r_done) begin
                    overrun_error <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_busy = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_oversampler
//  Description : Self-checking bench for uart_rx_oversampler. Two instances:
//                dut0 at default settings, dut1 with even parity at a faster
//                baud. Expected words are computed from the transmitted frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampler;

    localparam int CLK_HZ = 50_000_000;
    localparam int OS     = 16;
    localparam int BAUD0  = 115_200;
    localparam int BAUD1  = 390_625;
    localparam int BIT0   = (CLK_HZ / (BAUD0 * OS)) * OS;   // 432 clocks
    localparam int BIT1   = (CLK_HZ / (BAUD1 * OS)) * OS;   // 128 clocks

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       line0  = 1'b1;
    logic       line1  = 1'b1;
    logic       ready0 = 1'b1;
    logic       ready1 = 1'b1;
    logic [6:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         words_seen[2];
    int         ov_seen[2];
    int         word_cyc[2];
    int         start_cyc[2];
    int         nexp[2];
    logic [8:0] held[2];
    logic       prev_v[2];
    logic       prev_r[2];
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    bit         rmode0 = 1'b0;
    bit         rmode1 = 1'b0;

    uart_rx_oversampler #(
        .CLK_FREQUENCY (CLK_HZ), .BAUD_RATE (BAUD0), .DATA_BITS (7),
        .OVERSAMPLE (OS), .PARITY (0)
    ) dut0 (
        .clk (clk), .reset (reset), .rx_serial (line0), .rx_ready (ready0),
        .rx_data (d0), .rx_valid (v0), .framing_error (fe0),
        .parity_error (pe0), .overrun_error (ov0), .rx_busy (busy0)
    );

    uart_rx_oversampler #(
        .CLK_FREQUENCY (CLK_HZ), .BAUD_RATE (BAUD1), .DATA_BITS (7),
        .OVERSAMPLE (OS), .PARITY (1)
    ) dut1 (
        .clk (clk), .reset (reset), .rx_serial (line1), .rx_ready (ready1),
        .rx_data (d1), .rx_valid (v1), .framing_error (fe1),
        .parity_error (pe1), .overrun_error (ov1), .rx_busy (busy1)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d: got 0x%0h want 0x%0h", name, k, got, want);
        end
    endtask

    // Expected {parity_error, framing_error, data} from the transmitted frame
    function automatic logic [8:0] model_word(input logic [6:0] data, input bit par_en,
                                              input logic par_bit, input logic stop_bit);
        logic pe;
        pe = par_en ? (par_bit != (^data)) : 1'b0;
        return {pe, ~stop_bit, data};
    endfunction

    // Per-cycle comparison against the expected-word queues
    always @(negedge clk) begin : compare
        logic       cv, cfe, cpe, cov, crd, cbusy, have;
        logic [6:0] cd;
        logic [8:0] e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                cv = v0; cd = d0; cfe = fe0; cpe = pe0; cov = ov0; crd = ready0; cbusy = busy0;
            end else begin
                cv = v1; cd = d1; cfe = fe1; cpe = pe1; cov = ov1; crd = ready1; cbusy = busy1;
            end
            if (!reset) begin
                check("reset_outputs", k, {20'd0, cv, cd, cfe, cpe, cov, cbusy}, 32'd0);
                prev_v[k] = 1'b0;
                prev_r[k] = 1'b0;
            end else begin
                if (cv && (!prev_v[k] || prev_r[k])) begin
                    have = 1'b0;
                    e    = '0;
                    if (k == 0 && exp_q0.size() > 0) begin
                        e = exp_q0.pop_front(); have = 1'b1;
                    end else if (k == 1 && exp_q1.size() > 0) begin
                        e = exp_q1.pop_front(); have = 1'b1;
                    end
                    if (have) begin
                        check("word", k, {23'd0, cpe, cfe, cd}, {23'd0, e});
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word dut%0d: got 0x%0h want none", k,
                                 {cpe, cfe, cd});
                    end
                    held[k]       = e;
                    words_seen[k] = words_seen[k] + 1;
                    word_cyc[k]   = cyc;
                end else if (cv) begin
                    check("hold_stable", k, {23'd0, cpe, cfe, cd}, {23'd0, held[k]});
                end
                if (cov) ov_seen[k] = ov_seen[k] + 1;
                prev_v[k] = cv;
                prev_r[k] = crd;
            end
        end
    end

    // Random consumer back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode0) ready0 = 1'($urandom_range(0, 1));
            if (rmode1) ready1 = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_ready(input int k, input logic b);
        @(posedge clk);
        #1;
        if (k == 0) ready0 = b; else ready1 = b;
    endtask

    task automatic drive(input int k, input logic b);
        if (k == 0) line0 = b; else line1 = b;
    endtask

    task automatic send_frame(input int k, input logic [6:0] data, input bit par_en,
                              input logic par_bit, input logic stop_bit, input int gap);
        int bl;
        bl = (k == 0) ? BIT0 : BIT1;
        @(negedge clk);
        start_cyc[k] = cyc;
        drive(k, 1'b0);
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            drive(k, data[i]);
            repeat (bl) @(negedge clk);
        end
        if (par_en) begin
            drive(k, par_bit);
            repeat (bl) @(negedge clk);
        end
        drive(k, stop_bit);
        repeat (bl) @(negedge clk);
        drive(k, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic expect_frame(input int k, input logic [6:0] data, input bit par_en,
                                input logic par_bit, input logic stop_bit);
        if (k == 0) exp_q0.push_back(model_word(data, par_en, par_bit, stop_bit));
        else        exp_q1.push_back(model_word(data, par_en, par_bit, stop_bit));
        nexp[k] = nexp[k] + 1;
    endtask

    task automatic wait_words(input int k, input int n, input int budget);
        int t;
        t = 0;
        while (words_seen[k] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("word_timeout", k, 32'(words_seen[k] >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         base, ovb, lat, gap;
        bit         busy_hi, par_en;
        logic [6:0] data;
        logic       pb, sb;

        for (int k = 0; k < 2; k++) begin
            words_seen[k] = 0; ov_seen[k] = 0; word_cyc[k] = 0; start_cyc[k] = 0;
            nexp[k] = 0; held[k] = '0; prev_v[k] = 1'b0; prev_r[k] = 1'b0;
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        repeat (BIT0) @(negedge clk);

        // Test 1: 7'h55 at defaults, latency from start edge
        set_ready(0, 1'b0);
        expect_frame(0, 7'h55, 1'b0, 1'b0, 1'b1);
        send_frame(0, 7'h55, 1'b0, 1'b0, 1'b1, 20);
        wait_words(0, nexp[0], 200);
        lat = word_cyc[0] - start_cyc[0];
        check("t1_latency_in_window", 0,
              32'((lat >= 8 * BIT0 + 200) && (lat <= 8 * BIT0 + 300)), 32'd1);
        check("t1_valid", 0, 32'(v0), 32'd1);
        check("t1_data", 0, 32'(d0), 32'h55);
        check("t1_flags", 0, 32'({fe0, pe0}), 32'd0);
        set_ready(0, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_consumed", 0, 32'(v0), 32'd0);

        // Test 2: one-tick glitch on the idle line
        base    = words_seen[0];
        busy_hi = 1'b0;
        @(negedge clk);
        drive(0, 1'b0);
        for (int i = 0; i < 37 + 2 * BIT0; i++) begin
            if (i == 37) drive(0, 1'b1);
            @(negedge clk);
            if (busy0) busy_hi = 1'b1;
        end
        check("t2_busy_pulsed", 0, 32'(busy_hi), 32'd1);
        check("t2_busy_idle", 0, 32'(busy0), 32'd0);
        check("t2_no_word", 0, 32'(words_seen[0]), 32'(base));

        // Test 3: framing error, then clean frame
        set_ready(0, 1'b0);
        expect_frame(0, 7'h2A, 1'b0, 1'b0, 1'b0);
        send_frame(0, 7'h2A, 1'b0, 1'b0, 1'b0, BIT0);
        wait_words(0, nexp[0], 200);
        check("t3_data", 0, 32'(d0), 32'h2A);
        check("t3_framing", 0, 32'(fe0), 32'd1);
        set_ready(0, 1'b1);
        repeat (2) @(negedge clk);
        set_ready(0, 1'b0);
        expect_frame(0, 7'h01, 1'b0, 1'b0, 1'b1);
        send_frame(0, 7'h01, 1'b0, 1'b0, 1'b1, 20);
        wait_words(0, nexp[0], 200);
        check("t3b_data", 0, 32'(d0), 32'h01);
        check("t3b_framing", 0, 32'(fe0), 32'd0);

        // Test 5: overrun with consumer stalled, back-to-back frames
        set_ready(0, 1'b1);
        repeat (2) @(negedge clk);
        set_ready(0, 1'b0);
        ovb = ov_seen[0];
        expect_frame(0, 7'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 7'h11, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, 7'h22, 1'b0, 1'b0, 1'b1, 20);
        wait_words(0, nexp[0], 200);
        check("t5_overrun_cycles", 0, 32'(ov_seen[0] - ovb), 32'd1);
        check("t5_data_kept", 0, 32'(d0), 32'h11);
        check("t5_valid_held", 0, 32'(v0), 32'd1);
        set_ready(0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_dropped", 0, 32'(v0), 32'd0);

        // Test 6: reset mid-frame, then a clean frame
        base = words_seen[0];
        @(negedge clk);
        drive(0, 1'b0);
        repeat (BIT0) @(negedge clk);
        drive(0, 1'b1);
        repeat (3 * BIT0 + BIT0 / 2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        repeat (2 * BIT0) @(negedge clk);
        check("t6_no_partial", 0, 32'(words_seen[0]), 32'(base));
        check("t6_idle", 0, 32'({v0, busy0}), 32'd0);
        set_ready(0, 1'b0);
        expect_frame(0, 7'h05, 1'b0, 1'b0, 1'b1);
        send_frame(0, 7'h05, 1'b0, 1'b0, 1'b1, 20);
        wait_words(0, nexp[0], 200);
        check("t6_data", 0, 32'(d0), 32'h05);
        check("t6_flags", 0, 32'({fe0, pe0}), 32'd0);
        set_ready(0, 1'b1);

        // Randomised frames on dut0 with random back-pressure
        rmode0 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            data = 7'($urandom);
            sb   = ($urandom_range(0, 3) != 0);
            expect_frame(0, data, 1'b0, 1'b0, sb);
            send_frame(0, data, 1'b0, 1'b0, sb, BIT0 + int'($urandom_range(0, 200)));
            wait_words(0, nexp[0], 200);
        end
        rmode0 = 1'b0;
        set_ready(0, 1'b1);

        // Test 4: even parity, wrong then correct parity bit
        set_ready(1, 1'b0);
        expect_frame(1, 7'h03, 1'b1, 1'b1, 1'b1);
        send_frame(1, 7'h03, 1'b1, 1'b1, 1'b1, 20);
        wait_words(1, nexp[1], 200);
        check("t4_parity_bad", 1, 32'(pe1), 32'd1);
        check("t4_data", 1, 32'(d1), 32'h03);
        set_ready(1, 1'b1);
        repeat (2) @(negedge clk);
        set_ready(1, 1'b0);
        expect_frame(1, 7'h03, 1'b1, 1'b0, 1'b1);
        send_frame(1, 7'h03, 1'b1, 1'b0, 1'b1, 20);
        wait_words(1, nexp[1], 200);
        check("t4_parity_good", 1, 32'(pe1), 32'd0);
        set_ready(1, 1'b1);
        repeat (2) @(negedge clk);

        // Break: line held low yields one flagged zero word and no retrigger
        base = words_seen[1];
        expect_frame(1, 7'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 1'b0);
        repeat (14 * BIT1) @(negedge clk);
        drive(1, 1'b1);
        repeat (3 * BIT1) @(negedge clk);
        check("break_one_word", 1, 32'(words_seen[1] - base), 32'd1);
        check("break_idle", 1, 32'(busy1), 32'd0);

        // Randomised parity frames on dut1
        rmode1 = 1'b1;
        for (int n = 0; n < 8; n++) begin
            data   = 7'($urandom);
            par_en = 1'b1;
            pb     = ($urandom_range(0, 3) == 0) ? ~(^data) : (^data);
            sb     = ($urandom_range(0, 3) != 0);
            gap    = sb ? int'($urandom_range(0, 1)) * int'($urandom_range(0, 150))
                        : 32 + int'($urandom_range(0, 150));
            expect_frame(1, data, par_en, pb, sb);
            send_frame(1, data, par_en, pb, sb, gap);
            wait_words(1, nexp[1], 200);
        end
        rmode1 = 1'b0;
        set_ready(1, 1'b1);
        repeat (10) @(negedge clk);

        check("queue0_drained", 0, 32'(exp_q0.size()), 32'd0);
        check("queue1_drained", 1, 32'(exp_q1.size()), 32'd0);
        check("overrun_total", 0, 32'(ov_seen[0]), 32'd1);
        check("overrun_total", 1, 32'(ov_seen[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
Serial receive front-end of the UART path; consumes the line driven by a peer transmitter's tx_serial and delivers parallel words to the local controller/FIFO. Synchronises the asynchronous line, oversamples each bit at OVERSAMPLE x baud, takes a 3-sample majority vote at mid-bit, and checks optional parity and the stop bit. Output is a valid/ready word interface with framing, parity and overrun status.

Parameters:
CLK_FREQUENCY, 50_000_000, system clock in Hz
BAUD_RATE, 115_200, line rate in bit/s
DATA_BITS, 7, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit (even, >=8)
PARITY, 0, 0 none / 1 even / 2 odd

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_serial  in  1  asynchronous serial line, idle high
rx_ready  in  1  consumer accepts rx_data this cycle
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data holds an unconsumed word
framing_error  out  1  stop bit of the held word sampled low
parity_error  out  1  parity mismatch on the held word (0 when PARITY=0)
overrun_error  out  1  one-cycle pulse: completed frame dropped
rx_busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): all outputs 0; synchroniser flops to 1; state IDLE; counters 0. Reset mid-frame aborts the frame; no partial word is delivered.
- Sync: 2-FF synchroniser on rx_serial; all logic uses the synchronised bit (2-cycle latency).
- Tick: DIV = CLK_FREQUENCY/(BAUD_RATE*OVERSAMPLE), integer truncation (27 at defaults); free-running counter 0..DIV-1; tick is a one-cycle strobe when count = DIV-1.
- Sample counter s runs 0..OVERSAMPLE-1 on ticks. Samples taken at s = M-1, M, M+1, where M = OVERSAMPLE/2. Vote = majority of 3, evaluated at s = M+1.
- States:
  - IDLE: on a tick with line=0, set s=0 and go to START.
  - START: at the vote, a result of 1 is a glitch; return to IDLE with no output. At s = OVERSAMPLE-1, go to DATA with bit index 0.
  - DATA: at the vote, shift the bit into bit[index]. At s = OVERSAMPLE-1, increment the index; after DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
  - PARITY: at the vote, compare against XOR of the data (even) or its inverse (odd); advance at s = OVERSAMPLE-1.
  - STOP: at the vote, complete the frame and return to IDLE immediately. Do not wait for the end of the bit, so a back-to-back start bit is not missed.
- Completion (cycle after the stop vote):
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, framing_error (stop=0), and parity_error; set rx_valid=1.
  - Else: keep the old word and flags, and pulse overrun_error for 1 cycle.
- A frame with a framing error is still delivered, flagged.
- Handshake: rx_valid && rx_ready consumes the word. rx_valid drops the next cycle unless a completion reloads it in that same cycle. rx_data and flags are stable while rx_valid=1. rx_ready while rx_valid=0 has no effect.
- Line held low (break): START passes, DATA captures 0s, STOP flags framing_error. The block stays in IDLE until the line goes high and then low again; it does not re-trigger while the line stays low. To implement this, IDLE arms only after seeing line=1 on a tick.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - function baud_div(clk, baud, os) returning DIV
- Sub-module uart_baud_tick (parameter DIV; ports clk, reset, tick), reusable by the transmitter.

Test Plan:
1. Defaults, send 7'h55 with 8.68 us bits (432 clk) -> rx_valid=1, rx_data=7'h55, both error flags 0; rx_valid within 432*(1+7)+~230+2 clk of the start edge.
2. 1-tick low glitch (37 clk) on the idle line -> state returns to IDLE, no rx_valid, rx_busy pulses then 0.
3. Send 7'h2A with stop bit driven low -> rx_valid=1, rx_data=7'h2A, framing_error=1; next frame 7'h01 with correct stop (after consume) -> framing_error=0.
4. PARITY=1, send 7'h03 with the parity bit set 1 (wrong) -> parity_error=1; parity bit 0 -> parity_error=0.
5. rx_ready held 0, send 7'h11 then 7'h22 back-to-back -> rx_data stays 7'h11, overrun_error pulses exactly 1 cycle; raising rx_ready then gives rx_valid=0 the next cycle.
6. Assert reset during bit 3 of 7'h7F, release, send 7'h05 -> no output for the aborted frame; rx_data=7'h05 delivered cleanly.
